// File: rtl/oclib_pkg.sv
// Shared definitions for the protection-gate blocks.
//
// Contents:
//   ProtectGateDefaultHold    default number of consecutive cycles `unlocked`
//                             must be high before the gate may open
//   ProtectGateStatsWidth     counter width assumed by CSR consumers of the
//                             statistics struct
//   protect_gate_stats_s      {passCount, blockCount} bundle for the CSR block
package oclib_pkg;

    localparam int ProtectGateDefaultHold = 16;
    localparam int ProtectGateStatsWidth  = 32;

    typedef struct packed {
        logic [ProtectGateStatsWidth-1:0] passCount;
        logic [ProtectGateStatsWidth-1:0] blockCount;
    } protect_gate_stats_s;

endpackage : oclib_pkg

// File: rtl/oc_protect_gate_qual.sv
// Unlock qualifier: filters the `unlocked` status so that the gate only sees
// an unlock that has been stable for UnlockHoldCycles consecutive cycles.
//
// Ports:
//   clock      in   sole clock
//   reset      in   synchronous, active-high
//   unlocked   in   raw unlock status from the protection block
//   qualified  out  unlock has been held long enough (and is still high)
module oc_protect_gate_qual
    import oclib_pkg::*;
#(
    parameter int UnlockHoldCycles = ProtectGateDefaultHold
) (
    input  logic clock,
    input  logic reset,
    input  logic unlocked,
    output logic qualified
);

    localparam int HoldWidth = $clog2(UnlockHoldCycles + 1);
    localparam logic [HoldWidth-1:0] HoldMax = HoldWidth'(UnlockHoldCycles);

    logic [HoldWidth-1:0] hold_q;
    logic [HoldWidth-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (!unlocked) begin
            hold_d = '0;
        end else if (hold_q != HoldMax) begin
            hold_d = hold_q + HoldWidth'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Gating with the live `unlocked` makes a drop take effect in the same
    // cycle, so the gate register can close one cycle after the low sample.
    assign qualified = unlocked && (hold_q == HoldMax);

endmodule : oc_protect_gate_qual

// File: rtl/oc_protect_gate.sv
// License-enforcement gate for a valid/ready packet stream. The gate opens
// only after `unlocked` is qualified and changes state only on packet
// boundaries, so downstream never sees a truncated packet.
//
// Build option: define OC_PROTECT_GATE_DROP_EN to consume and discard
// traffic while closed (drop mode); otherwise the closed gate backpressures
// upstream (backpressure mode).
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   unlocked              unlock status from the protection block
//   inValid/inReady       upstream handshake
//   inData/inLast         upstream payload and end-of-packet marker
//   outValid/outReady     downstream handshake
//   outData/outLast       downstream payload and end-of-packet marker
//   gateOpen              gate state currently applied to traffic
//   passCount             packets forwarded (saturating)
//   blockCount            packets dropped (drop mode) or blocked cycles
//                         (backpressure mode), saturating
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// outValid never depends on outReady; while open the path is purely
// combinational (no storage), while closed outValid is held low.
module oc_protect_gate
    import oclib_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int UnlockHoldCycles = ProtectGateDefaultHold,
    parameter int CountWidth       = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  unlocked,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DataWidth-1:0]  inData,
    input  logic                  inLast,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DataWidth-1:0]  outData,
    output logic                  outLast,
    output logic                  gateOpen,
    output logic [CountWidth-1:0] passCount,
    output logic [CountWidth-1:0] blockCount
);

    logic qualified;

    oc_protect_gate_qual #(
        .UnlockHoldCycles(UnlockHoldCycles)
    ) u_qual (
        .clock    (clock),
        .reset    (reset),
        .unlocked (unlocked),
        .qualified(qualified)
    );

    logic gate_q, gate_d;
    logic in_packet_q, in_packet_d;
    logic [CountWidth-1:0] pass_q, pass_d;
    logic [CountWidth-1:0] block_q, block_d;

    logic accept;
    logic closed_ready;
    logic pass_evt;
    logic block_evt;

`ifdef OC_PROTECT_GATE_DROP_EN
    // Closed gate swallows traffic; count whole discarded packets.
    assign closed_ready = 1'b1;
    assign block_evt    = accept & inLast & ~gate_q;
`else
    // Closed gate stalls upstream; count every stalled cycle.
    assign closed_ready = 1'b0;
    assign block_evt    = inValid & ~gate_q;
`endif

    assign inReady  = gate_q ? outReady : closed_ready;
    assign outValid = gate_q & inValid;
    assign outData  = inData;
    assign outLast  = inLast;
    assign gateOpen = gate_q;

    assign accept   = inValid & inReady;
    assign pass_evt = accept & inLast & gate_q;

    always_comb begin
        in_packet_d = in_packet_q;
        gate_d      = gate_q;
        pass_d      = pass_q;
        block_d     = block_q;

        if (accept) begin
            in_packet_d = ~inLast;
        end
        // Only resample the qualifier when the next beat starts a packet, so
        // every beat of a packet sees the same gate value.
        if (!in_packet_d) begin
            gate_d = qualified;
        end
        if (pass_evt && (pass_q != '1)) begin
            pass_d = pass_q + CountWidth'(1);
        end
        if (block_evt && (block_q != '1)) begin
            block_d = block_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gate_q      <= 1'b0;
            in_packet_q <= 1'b0;
            pass_q      <= '0;
            block_q     <= '0;
        end else begin
            gate_q      <= gate_d;
            in_packet_q <= in_packet_d;
            pass_q      <= pass_d;
            block_q     <= block_d;
        end
    end

    assign passCount  = pass_q;
    assign blockCount = block_q;

endmodule : oc_protect_gate

// File: tb/tb_oc_protect_gate.sv
// Directed bench for oc_protect_gate. Two instances share all inputs: a wide
// counter build and a 2-bit counter build used for saturation checks.
module tb_oc_protect_gate;

    localparam int Dw   = 16;
    localparam int Hold = 4;
    localparam int Cw   = 8;

`ifdef OC_PROTECT_GATE_DROP_EN
    localparam logic DropMode = 1'b1;
`else
    localparam logic DropMode = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          unlocked;
    logic          inValid;
    logic [Dw-1:0] inData;
    logic          inLast;
    logic          outReady;

    logic          inReady, outValid, outLast, gateOpen;
    logic [Dw-1:0] outData;
    logic [Cw-1:0] passCount, blockCount;

    logic          s_inReady, s_outValid, s_outLast, s_gateOpen;
    logic [Dw-1:0] s_outData;
    logic [1:0]    s_passCount, s_blockCount;

    int checks = 0;
    int errors = 0;

    logic [Dw:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    oc_protect_gate #(.DataWidth(Dw), .UnlockHoldCycles(Hold), .CountWidth(Cw)) dut (
        .clock(clock), .reset(reset), .unlocked(unlocked),
        .inValid(inValid), .inReady(inReady), .inData(inData), .inLast(inLast),
        .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast),
        .gateOpen(gateOpen), .passCount(passCount), .blockCount(blockCount)
    );

    oc_protect_gate #(.DataWidth(Dw), .UnlockHoldCycles(Hold), .CountWidth(2)) dut_sat (
        .clock(clock), .reset(reset), .unlocked(unlocked),
        .inValid(inValid), .inReady(s_inReady), .inData(inData), .inLast(inLast),
        .outValid(s_outValid), .outReady(outReady), .outData(s_outData), .outLast(s_outLast),
        .gateOpen(s_gateOpen), .passCount(s_passCount), .blockCount(s_blockCount)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the rising edge; checks run at +3.
    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset   = 1'b1;
        inValid = 1'b0;
        inLast  = 1'b0;
        next_cycle();
        reset   = 1'b0;
    endtask

    // Drive one beat for one cycle; when it should pass, queue it as expected.
    task automatic drive_beat(input logic [Dw-1:0] data, input logic last, input logic expect_out);
        inValid = 1'b1;
        inData  = data;
        inLast  = last;
        if (expect_out) exp_q.push_back({last, data});
        #1;
        check("beat_outValid", outValid, expect_out);
        next_cycle();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (!reset && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {outLast, outData}, '1);
            end else begin
                check("out_beat", {outLast, outData}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        unlocked = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check("rst_gateOpen", gateOpen, 0);
        check("rst_outValid", outValid, 0);
        check("rst_inReady", inReady, DropMode);
        check("rst_passCount", passCount, 0);
        check("rst_blockCount", blockCount, 0);

        // Hold time: high sampled on edges 1..4, gate opens after edge 5.
        unlocked = 1'b1;
        for (int i = 1; i <= Hold; i++) begin
            next_cycle();
            check("hold_gate_closed", gateOpen, 0);
        end
        next_cycle();
        check("hold_gate_open", gateOpen, 1);

        // Close latency: one low sample closes the gate on the next cycle.
        unlocked = 1'b0;
        next_cycle();
        check("close_latency", gateOpen, 0);
        check("close_hold_clear", dut.u_qual.hold_q, 0);

        // Glitch rejection.
        unlocked = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        check("glitch_hold3", dut.u_qual.hold_q, 3);
        unlocked = 1'b0;
        next_cycle();
        check("glitch_hold_reset", dut.u_qual.hold_q, 0);
        unlocked = 1'b1;
        for (int i = 0; i < Hold; i++) begin
            next_cycle();
            check("glitch_gate_closed", gateOpen, 0);
        end
        check("glitch_hold4", dut.u_qual.hold_q, 4);
        next_cycle();
        check("glitch_gate_open", gateOpen, 1);

        // Mid-packet close: 5-beat packet, unlock drops after beat 2.
        for (int i = 0; i < 5; i++) begin
            drive_beat(16'h00A0 + 16'(i), (i == 4), 1'b1);
            if (i == 1) unlocked = 1'b0;
            if (i == 2) check("midpkt_gate_held", gateOpen, 1);
        end
        check("midpkt_gate_closed", gateOpen, 0);
        check("midpkt_passCount", passCount, 1);
        check("midpkt_queue_drained", exp_q.size(), 0);
        inValid = 1'b1;
        inData  = 16'h00BB;
        inLast  = 1'b1;
        #1;
        check("next_pkt_outValid", outValid, 0);
        check("next_pkt_inReady", inReady, DropMode);
        next_cycle();
        inValid = 1'b0;
        inLast  = 1'b0;
        #1;
        check("next_pkt_blockCount", blockCount, 1);
        check("next_pkt_passCount", passCount, 1);

        pulse_reset();
`ifdef OC_PROTECT_GATE_DROP_EN
        // Drop mode: unlock qualifies on beat 1's edge; packet still dropped.
        unlocked = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        drive_beat(16'h0C01, 1'b0, 1'b0);
        inValid = 1'b1;
        inData  = 16'h0C02;
        #1;
        check("drop_inReady", inReady, 1);
        check("drop_gate_held", gateOpen, 0);
        next_cycle();
        drive_beat(16'h0C03, 1'b1, 1'b0);
        check("drop_blockCount", blockCount, 1);
        check("drop_gate_open", gateOpen, 1);
        drive_beat(16'h0D01, 1'b0, 1'b1);
        drive_beat(16'h0D02, 1'b1, 1'b1);
        check("drop_passCount", passCount, 1);
        check("drop_queue_drained", exp_q.size(), 0);
`else
        // Backpressure mode: locked, inValid held 10 cycles.
        inValid = 1'b1;
        inData  = 16'h0BAD;
        inLast  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_inReady", inReady, 0);
            check("bp_outValid", outValid, 0);
            next_cycle();
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        #1;
        check("bp_blockCount", blockCount, 10);
        check("bp_blockCount_sat", s_blockCount, 3);
        check("bp_passCount", passCount, 0);
`endif

        // Saturation and reset.
        unlocked = 1'b1;
        pulse_reset();
        for (int i = 0; i <= Hold; i++) next_cycle();
        check("sat_gate_open", gateOpen, 1);
        outReady = 1'b0;
        inValid  = 1'b1;
        inLast   = 1'b1;
        #1;
        check("stall_outValid", outValid, 1);
        check("stall_inReady", inReady, 0);
        outReady = 1'b1;
        inValid  = 1'b0;
        for (int i = 0; i < 5; i++) drive_beat(16'h0500 + 16'(i), 1'b1, 1'b1);
        #1;
        check("sat_passCount_wide", passCount, 5);
        check("sat_passCount_2b", s_passCount, 3);
        drive_beat(16'h0E01, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        reset = 1'b1;
        next_cycle();
        #1;
        check("rst2_passCount", passCount, 0);
        check("rst2_passCount_2b", s_passCount, 0);
        check("rst2_blockCount", blockCount, 0);
        check("rst2_gateOpen", gateOpen, 0);
        check("rst2_outValid", outValid, 0);
        reset = 1'b0;
        for (int i = 0; i <= Hold; i++) next_cycle();
        drive_beat(16'h0F01, 1'b1, 1'b1);
        #1;
        check("rst2_fresh_packet", passCount, 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_oc_protect_gate
